// File: rtl/io_port_bank_if.sv
// Bus/handshake bundle between the CPU datapath, the devices and io_port_bank.
// The master side is the CPU and the devices. The slave side is the port bank.
interface io_port_bank_if #(
  parameter int WIDTH     = 32,
  parameter int NUM_PORTS = 4
);
  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // CPU OUT path
  logic [WIDTH-1:0]           bus_in;
  logic                       out_wr;
  logic [SEL_W-1:0]           out_sel;
  logic [NUM_PORTS-1:0]       out_full;
  logic [NUM_PORTS-1:0]       out_err;
  // Output channels towards the devices
  logic [NUM_PORTS*WIDTH-1:0] port_data;
  logic [NUM_PORTS-1:0]       port_valid;
  logic [NUM_PORTS-1:0]       port_ready;
  // Input channel from the device and CPU IN path
  logic [WIDTH-1:0]           in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_rd;
  logic [WIDTH-1:0]           bus_out;
  logic                       in_avail;
  logic                       in_overrun;
  // Status maintenance
  logic                       status_clr;

  modport master (
    output bus_in, out_wr, out_sel, port_ready, in_data, in_valid, in_rd, status_clr,
    input  out_full, out_err, port_data, port_valid, in_ready, bus_out, in_avail, in_overrun
  );

  modport slave (
    input  bus_in, out_wr, out_sel, port_ready, in_data, in_valid, in_rd, status_clr,
    output out_full, out_err, port_data, port_valid, in_ready, bus_out, in_avail, in_overrun
  );
endinterface

// File: rtl/io_port_bank.sv
// Port bank for the CPU datapath. It has NUM_PORTS show-ahead output FIFOs that are
// loaded by OUT and drained over valid/ready. It also has one handshaked input holding
// register that is read by IN.
module io_port_bank #(
  parameter int WIDTH       = 32,
  parameter int NUM_PORTS   = 4,
  parameter int DEPTH       = 4,
  parameter int IN_BLOCKING = 1
) (
  input  logic           clock,
  input  logic           clear,
  io_port_bank_if.slave  bus
);
  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam bit BLOCK = (IN_BLOCKING != 0);

  logic [NUM_PORTS-1:0]       valid_s;
  logic [NUM_PORTS-1:0]       full_s;
  logic [NUM_PORTS-1:0]       err_s;
  logic [NUM_PORTS*WIDTH-1:0] data_s;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_ch
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             err_r;
    logic             hit_s;
    logic             full_ch_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;

    // An out_sel value beyond the last channel matches no channel, so the write is ignored.
    assign hit_s     = bus.out_wr && (bus.out_sel == SEL_W'(i));
    assign full_ch_s = (cnt_r == CNT_W'(DEPTH));
    assign pop_s     = (cnt_r != {CNT_W{1'b0}}) && bus.port_ready[i];
    // A full channel still takes a word if its head leaves on the same edge.
    assign push_s    = hit_s && (!full_ch_s || pop_s);
    assign drop_s    = hit_s && full_ch_s && !pop_s;

    // Pointer, occupancy and sticky overflow bookkeeping for this channel
    always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
        rd_ptr_r <= {PTR_W{1'b0}};
        wr_ptr_r <= {PTR_W{1'b0}};
        cnt_r    <= {CNT_W{1'b0}};
        err_r    <= 1'b0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
        if (push_s && !pop_s) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
          cnt_r <= cnt_r - CNT_W'(1);
        end
        // A new drop takes priority over a clear in the same cycle.
        if (drop_s) begin
          err_r <= 1'b1;
        end else if (bus.status_clr) begin
          err_r <= 1'b0;
        end
      end
    end

    // Word storage. An entry is meaningful only while the count covers it.
    always_ff @(posedge clock) begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.bus_in;
      end
    end

    assign valid_s[i]                = (cnt_r != {CNT_W{1'b0}});
    assign full_s[i]                 = full_ch_s;
    assign err_s[i]                  = err_r;
    assign data_s[i*WIDTH +: WIDTH]  = valid_s[i] ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
  end

  assign bus.port_valid = valid_s;
  assign bus.out_full   = full_s;
  assign bus.out_err    = err_s;
  assign bus.port_data  = data_s;

  // Input holding register
  logic [WIDTH-1:0] hold_r;
  logic             avail_r;
  logic             overrun_r;
  logic             in_ready_s;
  logic             capture_s;
  logic             overrun_evt_s;

  assign in_ready_s    = BLOCK ? (!avail_r || bus.in_rd) : 1'b1;
  assign capture_s     = bus.in_valid && in_ready_s;
  assign overrun_evt_s = !BLOCK && capture_s && avail_r && !bus.in_rd;

  // Capture device words into the holding register and track unread/overrun state
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      hold_r    <= {WIDTH{1'b0}};
      avail_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (capture_s) begin
        hold_r  <= bus.in_data;
        avail_r <= 1'b1;
      end else if (bus.in_rd) begin
        avail_r <= 1'b0;
      end
      if (overrun_evt_s) begin
        overrun_r <= 1'b1;
      end else if (bus.status_clr) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.bus_out    = hold_r;
  assign bus.in_avail   = avail_r;
  assign bus.in_overrun = overrun_r;
endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank. dut_a uses blocking input. dut_b uses overwrite
// input and receives the same device/IN stimulus. A scoreboard monitor checks
// popped words and read words.
module tb_io_port_bank;
  localparam int W  = 32;
  localparam int NP = 3;
  localparam int D  = 4;
  localparam int SW = 2;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  io_port_bank_if #(.WIDTH(W), .NUM_PORTS(NP)) ifa ();
  io_port_bank_if #(.WIDTH(W), .NUM_PORTS(NP)) ifb ();

  io_port_bank #(.WIDTH(W), .NUM_PORTS(NP), .DEPTH(D), .IN_BLOCKING(1)) dut_a (
    .clock(clock), .clear(clear), .bus(ifa.slave));
  io_port_bank #(.WIDTH(W), .NUM_PORTS(NP), .DEPTH(D), .IN_BLOCKING(0)) dut_b (
    .clock(clock), .clear(clear), .bus(ifb.slave));

  assign ifb.bus_in     = {W{1'b0}};
  assign ifb.out_wr     = 1'b0;
  assign ifb.out_sel    = {SW{1'b0}};
  assign ifb.port_ready = {NP{1'b0}};
  assign ifb.in_data    = ifa.in_data;
  assign ifb.in_valid   = ifa.in_valid;
  assign ifb.in_rd      = ifa.in_rd;
  assign ifb.status_clr = ifa.status_clr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO occupancy and expected words per channel, plus the input register state.
  int           cnt_m [NP];
  bit           err_m [NP];
  logic [W-1:0] exp_q [NP][$];
  logic [W-1:0] in_q [$];
  logic [W-1:0] hold_a, hold_b;
  bit           avail_a, avail_b, ovr_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      cnt_m[i] = 0;
      err_m[i] = 1'b0;
      exp_q[i].delete();
    end
    in_q.delete();
    hold_a = '0; hold_b = '0;
    avail_a = 1'b0; avail_b = 1'b0; ovr_b = 1'b0;
  endtask

  // Applies this cycle's inputs to the model just before the clock edge.
  task automatic model_update();
    bit pop_m [NP];
    bit ovr_set;
    int s;
    chk("a_in_ready", ifa.in_ready, !avail_a || ifa.in_rd);
    chk("b_in_ready", ifb.in_ready, 1'b1);
    for (int i = 0; i < NP; i++) pop_m[i] = (cnt_m[i] > 0) && ifa.port_ready[i];
    if (ifa.status_clr) for (int i = 0; i < NP; i++) err_m[i] = 1'b0;
    if (ifa.out_wr && int'(ifa.out_sel) < NP) begin
      s = int'(ifa.out_sel);
      if (cnt_m[s] < D || pop_m[s]) begin
        exp_q[s].push_back(ifa.bus_in);
        cnt_m[s]++;
      end else begin
        err_m[s] = 1'b1;
      end
    end
    for (int i = 0; i < NP; i++) if (pop_m[i]) cnt_m[i]--;
    // blocking input: accepted only when empty or being read
    if (ifa.in_valid && (!avail_a || ifa.in_rd)) begin
      hold_a = ifa.in_data; avail_a = 1'b1; in_q.push_back(ifa.in_data);
    end else if (ifa.in_rd) begin
      avail_a = 1'b0;
    end
    // overwrite input: always accepted
    ovr_set = 1'b0;
    if (ifb.in_valid) begin
      if (avail_b && !ifb.in_rd) ovr_set = 1'b1;
      hold_b = ifb.in_data; avail_b = 1'b1;
    end else if (ifb.in_rd) begin
      avail_b = 1'b0;
    end
    if (ifb.status_clr) ovr_b = 1'b0;
    if (ovr_set) ovr_b = 1'b1;
  endtask

  task automatic check_state();
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("port_valid%0d", i), ifa.port_valid[i], cnt_m[i] > 0);
      chk($sformatf("out_full%0d", i), ifa.out_full[i], cnt_m[i] == D);
      chk($sformatf("out_err%0d", i), ifa.out_err[i], err_m[i]);
      if (cnt_m[i] == 0) chk($sformatf("idle_data%0d", i), ifa.port_data[i*W +: W], '0);
    end
    chk("a_in_avail", ifa.in_avail, avail_a);
    chk("a_bus_out", ifa.bus_out, hold_a);
    chk("b_in_avail", ifb.in_avail, avail_b);
    chk("b_bus_out", ifb.bus_out, hold_b);
    chk("b_in_overrun", ifb.in_overrun, ovr_b);
  endtask

  // One clock cycle: inputs are already set at the falling edge.
  task automatic cycle();
    #1;
    model_update();
    @(posedge clock);
    @(negedge clock);
    check_state();
  endtask

  task automatic drive(input bit wr, input int sel, input logic [W-1:0] d,
                       input logic [NP-1:0] rdy, input bit iv, input logic [W-1:0] id,
                       input bit rd, input bit clr);
    ifa.out_wr = wr; ifa.out_sel = SW'(sel); ifa.bus_in = d;
    ifa.port_ready = rdy; ifa.in_valid = iv; ifa.in_data = id;
    ifa.in_rd = rd; ifa.status_clr = clr;
    cycle();
  endtask

  task automatic idle_inputs();
    ifa.out_wr = 1'b0; ifa.out_sel = '0; ifa.bus_in = '0; ifa.port_ready = '0;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_rd = 1'b0; ifa.status_clr = 1'b0;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    idle_inputs();
    #1;
    chk("rst_port_valid", ifa.port_valid, '0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    clear = 1'b1;
    check_state();
    chk("rst_in_ready", ifa.in_ready, 1'b1);
    chk("rst_port_data", ifa.port_data, '0);
  endtask

  // Scoreboard monitor: it checks every handshake the DUT actually performs.
  always @(negedge clock) begin
    logic [W-1:0] e;
    #2;
    if (clear) begin
      for (int i = 0; i < NP; i++) begin
        if (ifa.port_valid[i] && ifa.port_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("unexpected_pop%0d", i), ifa.port_data[i*W +: W], 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("pop_data%0d", i), ifa.port_data[i*W +: W], e);
          end
        end
      end
      if (ifa.in_rd && ifa.in_avail) begin
        if (in_q.size() == 0) begin
          chk("unexpected_read", ifa.bus_out, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = in_q.pop_front();
          chk("read_data", ifa.bus_out, e);
        end
      end
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    @(negedge clock);
    do_reset();

    // Two words to channel 2 while it is stalled, then drain it
    drive(1'b1, 2, 32'hB980_0000, 3'b000, 1'b0, '0, 1'b0, 1'b0);
    chk("ch2_valid_first", ifa.port_valid[2], 1'b1);
    chk("ch2_head_first", ifa.port_data[2*W +: W], 32'hB980_0000);
    drive(1'b1, 2, 32'h5678_1234, 3'b000, 1'b0, '0, 1'b0, 1'b0);
    chk("ch2_head_hold", ifa.port_data[2*W +: W], 32'hB980_0000);
    drive(1'b0, 0, '0, 3'b100, 1'b0, '0, 1'b0, 1'b0);
    chk("ch2_head_second", ifa.port_data[2*W +: W], 32'h5678_1234);
    drive(1'b0, 0, '0, 3'b100, 1'b0, '0, 1'b0, 1'b0);
    chk("ch2_empty", ifa.port_valid[2], 1'b0);

    // Fill channel 0, overflow it, push through while full, then clear the flag
    for (int k = 0; k < 4; k++) drive(1'b1, 0, 32'h100 + k, 3'b000, 1'b0, '0, 1'b0, 1'b0);
    chk("ch0_full_after_4", ifa.out_full[0], 1'b1);
    chk("ch0_no_err_yet", ifa.out_err[0], 1'b0);
    drive(1'b1, 0, 32'hDEAD_0005, 3'b000, 1'b0, '0, 1'b0, 1'b0);
    chk("ch0_err_on_drop", ifa.out_err[0], 1'b1);
    drive(1'b1, 0, 32'h0000_00AA, 3'b001, 1'b0, '0, 1'b0, 1'b0);
    chk("ch0_full_pushpop", ifa.out_full[0], 1'b1);
    drive(1'b0, 0, '0, 3'b000, 1'b0, '0, 1'b0, 1'b1);
    chk("ch0_err_cleared", ifa.out_err[0], 1'b0);
    for (int k = 0; k < 5; k++) drive(1'b0, 0, '0, 3'b001, 1'b0, '0, 1'b0, 1'b0);

    // Out-of-range select is ignored
    drive(1'b1, 3, 32'hBAD0_0003, 3'b000, 1'b0, '0, 1'b0, 1'b0);
    chk("bad_sel_no_valid", ifa.port_valid, '0);
    chk("bad_sel_no_err", ifa.out_err, '0);

    // Steady push+pop on a count-1 channel across pointer wraps
    drive(1'b1, 1, 32'h1000, 3'b000, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) drive(1'b1, 1, 32'h1001 + k, 3'b010, 1'b0, '0, 1'b0, 1'b0);
    chk("ch1_still_one", ifa.port_valid[1], 1'b1);
    drive(1'b0, 0, '0, 3'b010, 1'b0, '0, 1'b0, 1'b0);
    chk("ch1_drained", ifa.port_valid[1], 1'b0);

    // Reset with two words buffered in channel 1
    drive(1'b1, 1, 32'hAAAA_0001, 3'b000, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1, 32'hAAAA_0002, 3'b000, 1'b0, '0, 1'b0, 1'b0);
    do_reset();

    // Blocking input: the second word is held off until the first is read
    drive(1'b0, 0, '0, 3'b000, 1'b1, 32'h0000_0042, 1'b0, 1'b0);
    chk("a_avail_set", ifa.in_avail, 1'b1);
    chk("a_ready_low", ifa.in_ready, 1'b0);
    drive(1'b0, 0, '0, 3'b000, 1'b1, 32'h0000_0043, 1'b0, 1'b0);
    chk("a_word_held", ifa.bus_out, 32'h0000_0042);
    drive(1'b0, 0, '0, 3'b000, 1'b1, 32'h0000_0043, 1'b1, 1'b0);
    chk("a_next_captured", ifa.bus_out, 32'h0000_0043);
    chk("a_avail_kept", ifa.in_avail, 1'b1);
    drive(1'b0, 0, '0, 3'b000, 1'b0, '0, 1'b1, 1'b1);
    chk("a_avail_cleared", ifa.in_avail, 1'b0);

    // Overwrite input: the unread word is replaced, then a read of an empty register
    drive(1'b0, 0, '0, 3'b000, 1'b1, 32'h11, 1'b0, 1'b0);
    drive(1'b0, 0, '0, 3'b000, 1'b1, 32'h22, 1'b0, 1'b0);
    chk("b_bus_out_22", ifb.bus_out, 32'h22);
    chk("b_overrun_set", ifb.in_overrun, 1'b1);
    drive(1'b0, 0, '0, 3'b000, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, 0, '0, 3'b000, 1'b0, '0, 1'b1, 1'b0);
    chk("b_empty_read_22", ifb.bus_out, 32'h22);
    chk("b_overrun_sticky", ifb.in_overrun, 1'b1);

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 4) != 0, int'($urandom_range(0, 3)), $urandom,
            NP'($urandom), $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 1) == 1, ($urandom % 16) == 0);
    end

    // Drain everything and confirm nothing is left outstanding
    for (int k = 0; k < 8; k++) drive(1'b0, 0, '0, 3'b111, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < NP; i++) chk($sformatf("leftover_out%0d", i), exp_q[i].size(), 0);
    chk("leftover_in", in_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
